iccm_port_arb: RTL and testbench

Arbiter and sequencer sharing the single-port instruction memory (ICCM) between two requesters:
- Fetch path: the TL-UL SRAM adapter serving core instruction fetch; read-only.
- Programming path: the UART boot-loader writer and debug-time readback; reads and writes.

The block replaces the static prog-reset address/write-enable mux in front of the ICCM. It grants one requester per cycle, tracks in-flight reads through the fixed memory latency, and routes each read response back to the requester that issued it.

---
 rtl/iccm_arb_pkg.sv | 21 ++
 rtl/iccm_arb_tag_pipe.sv | 30 +++
 rtl/iccm_port_arb.sv | 125 ++++++++++++
 tb/tb_iccm_port_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared types and default parameters for the ICCM port arbiter.
package iccm_arb_pkg;

  localparam int unsigned ICCM_AW         = 12;
  localparam int unsigned ICCM_DW         = 32;
  localparam int unsigned ICCM_MEM_LAT    = 1;
  localparam int unsigned ICCM_STARVE_MAX = 8;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_PROG  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWN_FETCH};

endpackage

// File: rtl/iccm_arb_tag_pipe.sv
// Fixed-depth shift register of read tags, one stage per cycle of ICCM latency.
module iccm_arb_tag_pipe
  import iccm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = ICCM_MEM_LAT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_push,
  output tag_t tag_last
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= TAG_EMPTY;
      end
    end else begin
      stages[0] <= tag_push;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_last = stages[DEPTH-1];

endmodule

// File: rtl/iccm_port_arb.sv
// Shares the single-port ICCM between instruction fetch and the programming path.
// Optional prog anti-starvation counter: define ICCM_ARB_STARVE_EN.
module iccm_port_arb
  import iccm_arb_pkg::*;
#(
  parameter int unsigned AW         = ICCM_AW,
  parameter int unsigned DW         = ICCM_DW,
  parameter int unsigned MEM_LAT    = ICCM_MEM_LAT,
  parameter int unsigned STARVE_MAX = ICCM_STARVE_MAX
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            prog_mode_i,
  input  logic            f_req_i,
  input  logic [AW-1:0]   f_addr_i,
  output logic            f_gnt_o,
  output logic [DW-1:0]   f_rdata_o,
  output logic            f_rvalid_o,
  input  logic            p_req_i,
  input  logic            p_we_i,
  input  logic [AW-1:0]   p_addr_i,
  input  logic [DW-1:0]   p_wdata_i,
  input  logic [DW/8-1:0] p_wmask_i,
  output logic            p_gnt_o,
  output logic [DW-1:0]   p_rdata_o,
  output logic            p_rvalid_o,
  output logic            m_req_o,
  output logic            m_we_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  output logic [DW/8-1:0] m_wmask_o,
  input  logic [DW-1:0]   m_rdata_i,
  input  logic            m_rvalid_i,
  output logic            err_o
);

  if (MEM_LAT == 0 || STARVE_MAX == 0) begin : g_bad_param
    $error("iccm_port_arb: MEM_LAT and STARVE_MAX must be at least 1");
  end

  logic prog_wins;
  tag_t tag_push;
  tag_t tag_last;

`ifdef ICCM_ARB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (!p_req_i || p_gnt_o) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign prog_wins = (starve_cnt == CW'(STARVE_MAX));
`else
  assign prog_wins = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the memory while it is held.
  always_comb begin
    f_gnt_o = 1'b0;
    p_gnt_o = 1'b0;
    if (rst_ni) begin
      if (prog_mode_i) begin
        p_gnt_o = p_req_i;
      end else if (p_req_i && (!f_req_i || prog_wins)) begin
        p_gnt_o = 1'b1;
      end else begin
        f_gnt_o = f_req_i;
      end
    end
  end

  always_comb begin
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_wmask_o = '0;
    tag_push  = TAG_EMPTY;
    if (f_gnt_o) begin
      m_req_o  = 1'b1;
      m_addr_o = f_addr_i;
      tag_push = '{valid: 1'b1, owner: OWN_FETCH};
    end else if (p_gnt_o) begin
      m_req_o   = 1'b1;
      m_we_o    = p_we_i;
      m_addr_o  = p_addr_i;
      m_wdata_o = p_wdata_i;
      m_wmask_o = p_wmask_i;
      tag_push  = '{valid: !p_we_i, owner: OWN_PROG};
    end
  end

  iccm_arb_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tag_push (tag_push),
    .tag_last (tag_last)
  );

  // Routing trusts the tag pipeline; m_rvalid_i only feeds the consistency check.
  always_comb begin
    f_rvalid_o = tag_last.valid && (tag_last.owner == OWN_FETCH);
    p_rvalid_o = tag_last.valid && (tag_last.owner == OWN_PROG);
    f_rdata_o  = f_rvalid_o ? m_rdata_i : '0;
    p_rdata_o  = p_rvalid_o ? m_rdata_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (m_rvalid_i != tag_last.valid) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iccm_port_arb.sv
// Scoreboard bench for iccm_port_arb: directed scenarios followed by randomized traffic.
module tb_iccm_port_arb;
  import iccm_arb_pkg::*;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned MW   = DW / 8;
  localparam int unsigned LAT  = 1;
  localparam int unsigned SMAX = 8;
`ifdef ICCM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pm, f_req, p_req, p_we;
  logic [AW-1:0] f_addr, p_addr;
  logic [DW-1:0] p_wdata;
  logic [MW-1:0] p_wmask;
  logic          f_gnt, f_rvalid, p_gnt, p_rvalid;
  logic [DW-1:0] f_rdata, p_rdata;
  logic          m_req, m_we, m_rvalid, err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [MW-1:0] m_wmask;
  logic          inject = 1'b0;

  always #5 clk = ~clk;

  iccm_port_arb #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .prog_mode_i(pm),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
    .f_rdata_o(f_rdata), .f_rvalid_o(f_rvalid),
    .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_wmask_i(p_wmask), .p_gnt_o(p_gnt), .p_rdata_o(p_rdata), .p_rvalid_o(p_rvalid),
    .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_wmask_o(m_wmask), .m_rdata_i(m_rdata), .m_rvalid_i(m_rvalid), .err_o(err)
  );

  // Memory attached to the DUT's m_* port, fixed latency LAT.
  logic [DW-1:0] mem_dut [1<<AW];
  logic [DW-1:0] mem_ref [1<<AW];
  logic [DW-1:0] rd_data [LAT];
  logic          rd_v    [LAT];

  always @(posedge clk) begin
    if (m_req && m_we)
      for (int b = 0; b < MW; b++)
        if (m_wmask[b]) mem_dut[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
    rd_v[0]    <= m_req && !m_we;
    rd_data[0] <= mem_dut[m_addr];
    for (int i = 1; i < LAT; i++) begin
      rd_v[i]    <= rd_v[i-1];
      rd_data[i] <= rd_data[i-1];
    end
  end
  assign m_rvalid = rd_v[LAT-1] | inject;
  assign m_rdata  = rd_data[LAT-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned   due;
    bit            own_prog;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  bit   run_mon = 1'b0;
  bit   exp_err = 1'b0;
  int   starve_run = 0;

  // Monitor: pops the expected response due this cycle and compares both response ports.
  always @(negedge clk) begin
    bit            ef, ep;
    logic [DW-1:0] fd, pd;
    exp_t          it;
    ef = 1'b0; ep = 1'b0; fd = '0; pd = '0;
    if (!rst_n) begin
      sbq.delete();
    end else if (run_mon) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        it = sbq.pop_front();
        if (it.own_prog) begin ep = 1'b1; pd = it.data; end
        else             begin ef = 1'b1; fd = it.data; end
      end
      chk("f_rvalid", 32'(f_rvalid), 32'(ef));
      chk("p_rvalid", 32'(p_rvalid), 32'(ep));
      chk("f_rdata", f_rdata, fd);
      chk("p_rdata", p_rdata, pd);
    end
  end

  // One arbitration cycle: inputs are already driven; predict, check, then advance.
  task automatic step(output bit gf, output bit gp);
    bit   ef, ep;
    exp_t it;
    ef = !pm && f_req;
    ep = p_req && (pm || !f_req || (STARVE && starve_run >= int'(SMAX)));
    @(negedge clk);
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("p_gnt", 32'(p_gnt), 32'(ep));
    chk("m_req", 32'(m_req), 32'(ef || ep));
    if (ef) begin
      chk("m_addr_f", 32'(m_addr), 32'(f_addr));
      chk("m_we_f", 32'(m_we), 32'(0));
      it.due = cyc + LAT; it.own_prog = 1'b0; it.data = mem_ref[f_addr];
      sbq.push_back(it);
    end else if (ep) begin
      chk("m_addr_p", 32'(m_addr), 32'(p_addr));
      chk("m_we_p", 32'(m_we), 32'(p_we));
      if (p_we) begin
        chk("m_wdata", m_wdata, p_wdata);
        chk("m_wmask", 32'(m_wmask), 32'(p_wmask));
        for (int b = 0; b < MW; b++)
          if (p_wmask[b]) mem_ref[p_addr][b*8 +: 8] = p_wdata[b*8 +: 8];
      end else begin
        it.due = cyc + LAT; it.own_prog = 1'b1; it.data = mem_ref[p_addr];
        sbq.push_back(it);
      end
    end else begin
      chk("m_we_idle", 32'(m_we), 32'(0));
    end
    chk("err", 32'(err), 32'(exp_err));
    if (inject) exp_err = 1'b1;
    if (p_req && !ep) starve_run = (starve_run < int'(SMAX)) ? starve_run + 1 : int'(SMAX);
    else              starve_run = 0;
    gf = ef; gp = ep;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    f_req = 1'b0; p_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_f_gnt"}, 32'(f_gnt), 32'(0));
    chk({tag, "_p_gnt"}, 32'(p_gnt), 32'(0));
    chk({tag, "_m_req"}, 32'(m_req), 32'(0));
    chk({tag, "_m_we"}, 32'(m_we), 32'(0));
    chk({tag, "_m_addr"}, 32'(m_addr), 32'(0));
    chk({tag, "_m_wdata"}, m_wdata, 32'(0));
    chk({tag, "_m_wmask"}, 32'(m_wmask), 32'(0));
    chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'(0));
    chk({tag, "_p_rvalid"}, 32'(p_rvalid), 32'(0));
    chk({tag, "_f_rdata"}, f_rdata, 32'(0));
    chk({tag, "_p_rdata"}, p_rdata, 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fg, pg;
    logic [DW-1:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      mem_dut[i] = v; mem_ref[i] = v;
    end
    mem_dut[12'h010] = 32'hDEADBEEF; mem_ref[12'h010] = 32'hDEADBEEF;
    for (int i = 0; i < LAT; i++) begin rd_v[i] = 1'b0; rd_data[i] = '0; end

    // Reset with both requesters active: everything must stay quiet.
    pm = 1'b0; f_req = 1'b1; p_req = 1'b1; p_we = 1'b1;
    f_addr = 12'h0AB; p_addr = 12'h0CD; p_wdata = 32'h12345678; p_wmask = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mon = 1'b1;

    // Fetch only
    f_req = 1'b1; f_addr = 12'h010;
    step(fg, pg);
    idle(); step(fg, pg);

    // Prog write in programming mode with fetch contending, then read back
    pm = 1'b1; f_req = 1'b1; f_addr = 12'h011;
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h004; p_wdata = 32'h00000013; p_wmask = 4'hF;
    step(fg, pg);
    p_we = 1'b0; step(fg, pg);
    idle(); step(fg, pg);
    p_req = 1'b1; p_we = 1'b1; p_addr = 12'h004; p_wdata = 32'hAABBCCDD; p_wmask = 4'h5;
    step(fg, pg);
    p_we = 1'b0; step(fg, pg);
    idle(); step(fg, pg);

    // Sustained contention in normal mode
    pm = 1'b0; f_req = 1'b1; f_addr = 12'h020; p_req = 1'b1; p_we = 1'b0; p_addr = 12'h004;
    repeat (20) step(fg, pg);
    idle(); step(fg, pg);

    // Mode rises right after a fetch read is granted
    pm = 1'b0; f_req = 1'b1; f_addr = 12'h030;
    step(fg, pg);
    pm = 1'b1; idle(); step(fg, pg);
    step(fg, pg);

    // Spurious memory valid with an empty pipeline
    inject = 1'b1; step(fg, pg);
    inject = 1'b0; step(fg, pg);
    repeat (2) step(fg, pg);

    // Reset in the middle of a granted fetch read
    pm = 1'b0; f_req = 1'b1; f_addr = 12'h040;
    @(negedge clk);
    chk("mid_f_gnt", 32'(f_gnt), 32'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("after_reset");
    idle(); exp_err = 1'b0; starve_run = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("released");
    @(posedge clk); #1;

    // Randomized traffic; a requester holds its command until granted.
    fg = 1'b1; pg = 1'b1; pm = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) pm = ~pm;
      if (!f_req || fg) begin
        f_req  = ($urandom_range(0, 2) != 0);
        f_addr = AW'($urandom_range(0, 15));
      end
      if (!p_req || pg) begin
        p_req   = ($urandom_range(0, 1) != 0);
        p_we    = ($urandom_range(0, 1) != 0);
        p_addr  = AW'($urandom_range(0, 15));
        p_wdata = $urandom;
        p_wmask = MW'($urandom_range(0, 15));
      end
      step(fg, pg);
    end
    idle();
    repeat (LAT + 1) step(fg, pg);
    chk("sb_drained", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
